fmul_arbiter: RTL and testbench



---
 rtl/fpu_pkg.sv | 23 ++
 rtl/fmul_core.sv | 38 +++
 rtl/fmul_arbiter.sv | 119 +++++++++++
 tb/tb_fmul_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// FP32 field layout and limits shared by the multiplier datapath and its arbiter.
package fpu_pkg;

   localparam int FP_W      = 32;
   localparam int SIGN_BIT  = 31;
   localparam int EXP_MSB   = 30;
   localparam int EXP_LSB   = 23;
   localparam int EXP_W     = 8;
   localparam int MANT_MSB  = 22;
   localparam int MANT_W    = 23;

   localparam int EXP_BIAS      = 127;
   localparam int OVF_EXP_LIMIT = 382;

   localparam logic [FP_W-1:0] FP32_ZERO = '0;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
   } fp32_t;

endpackage

// File: rtl/fmul_core.sv
// Combinational FP32 multiply: truncating mantissa product, zero/underflow/overflow
// all collapse to a zero result with ovf set.
module fmul_core
   import fpu_pkg::*;
(
   input  logic [FP_W-1:0] x1_i,
   input  logic [FP_W-1:0] x2_i,
   output logic [FP_W-1:0] y_o,
   output logic            ovf_o
);

   fp32_t              a, b;
   logic [23:0]        ma, mb;
   logic [47:0]        prod;
   logic [9:0]         esum;
   logic [9:0]         e_res;
   logic               norm;
   logic [MANT_W-1:0]  mant;
   logic               sgn;

   always_comb begin
      a     = x1_i;
      b     = x2_i;
      ma    = {1'b1, a.mant};
      mb    = {1'b1, b.mant};
      prod  = ma * mb;
      sgn   = a.sign ^ b.sign;
      esum  = {2'b00, a.exp} + {2'b00, b.exp};
      norm  = prod[47];
      // Wraps when esum is small, but that range is flagged as ovf below.
      e_res = esum - 10'(EXP_BIAS) + {9'b0, norm};
      mant  = norm ? prod[46:24] : prod[45:23];
      ovf_o = (a.exp == '0) || (b.exp == '0) ||
              (esum <= 10'(EXP_BIAS)) || (esum >= 10'(OVF_EXP_LIMIT));
      y_o   = ovf_o ? FP32_ZERO : {sgn, e_res[EXP_W-1:0], mant};
   end

endmodule

// File: rtl/fmul_arbiter.sv
// Round-robin share of one fmul_core among NREQ requesters, with a fixed two-register
// pipeline, tagged one-hot responses and per-requester saturating ovf counters.
module fmul_arbiter
   import fpu_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*FP_W-1:0]  req_x1,
   input  logic [NREQ*FP_W-1:0]  req_x2,
   output logic [NREQ-1:0]       resp_valid,
   output logic [FP_W-1:0]       resp_y,
   output logic                  resp_ovf,
   output logic                  busy,
   output logic [NREQ*CNT_W-1:0] ovf_cnt,
   input  logic                  cnt_clr
);

   localparam int IDX_W = (NREQ > 2) ? 2 : 1;

   logic [IDX_W-1:0]             rr_last_q;
   logic [NREQ-1:0]              grant;
   logic [IDX_W-1:0]             gnt_idx;
   logic                         accept;

   logic                         s1_vld_q;
   logic [FP_W-1:0]              s1_x1_q, s1_x2_q;
   logic [IDX_W-1:0]             s1_tag_q;

   logic [FP_W-1:0]              core_y;
   logic                         core_ovf;

   logic [NREQ-1:0]              resp_valid_q;
   logic [FP_W-1:0]              resp_y_q;
   logic                         resp_ovf_q;
   logic [NREQ-1:0][CNT_W-1:0]   cnt_q;

   // Search starts just past the last winner, so the last winner has lowest priority.
   always_comb begin
      int idx;
      idx     = 0;
      grant   = '0;
      gnt_idx = '0;
      accept  = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(rr_last_q) + k) % NREQ;
         if (!accept && req_valid[idx]) begin
            accept     = 1'b1;
            gnt_idx    = IDX_W'(idx);
            grant[idx] = 1'b1;
         end
      end
   end

   assign req_ready = grant;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_last_q <= IDX_W'(NREQ - 1);
         s1_vld_q  <= 1'b0;
         s1_x1_q   <= '0;
         s1_x2_q   <= '0;
         s1_tag_q  <= '0;
      end else begin
         s1_vld_q <= accept;
         if (accept) begin
            rr_last_q <= gnt_idx;
            s1_x1_q   <= req_x1[FP_W*int'(gnt_idx) +: FP_W];
            s1_x2_q   <= req_x2[FP_W*int'(gnt_idx) +: FP_W];
            s1_tag_q  <= gnt_idx;
         end
      end
   end

   fmul_core u_core (
      .x1_i  (s1_x1_q),
      .x2_i  (s1_x2_q),
      .y_o   (core_y),
      .ovf_o (core_ovf)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         resp_valid_q <= '0;
         resp_ovf_q   <= 1'b0;
         resp_y_q     <= '0;
      end else begin
         resp_valid_q <= s1_vld_q ? (NREQ'(1) << s1_tag_q) : '0;
         resp_ovf_q   <= s1_vld_q & core_ovf;
         if (s1_vld_q)
            resp_y_q <= core_ovf ? FP32_ZERO : core_y;
      end
   end

   // Counters observe the registered response, so they lag it by one cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (cnt_clr)
               cnt_q[i] <= '0;
            else if (resp_valid_q[i] && resp_ovf_q && !(&cnt_q[i]))
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
         end
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_y     = resp_y_q;
   assign resp_ovf   = resp_ovf_q;
   assign busy       = s1_vld_q | (|resp_valid_q);
   assign ovf_cnt    = cnt_q;

endmodule

// File: tb/tb_fmul_arbiter.sv
// Directed bench for fmul_arbiter (NREQ=2, CNT_W=4): arbitration order, pipeline
// latency, arithmetic, ovf flagging, counter saturation/clear, reset and idle hold.
module tb_fmul_arbiter;

   localparam int NREQ  = 2;
   localparam int CNT_W = 4;

   logic                  clk = 1'b0;
   logic                  rstn;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*32-1:0]    req_x1, req_x2;
   logic [NREQ-1:0]       resp_valid;
   logic [31:0]           resp_y;
   logic                  resp_ovf;
   logic                  busy;
   logic [NREQ*CNT_W-1:0] ovf_cnt;
   logic                  cnt_clr;

   int n_cmp = 0;
   int n_err = 0;

   fmul_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_x1     (req_x1),
      .req_x2     (req_x2),
      .resp_valid (resp_valid),
      .resp_y     (resp_y),
      .resp_ovf   (resp_ovf),
      .busy       (busy),
      .ovf_cnt    (ovf_cnt),
      .cnt_clr    (cnt_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      cnt_clr   = 1'b0;
      rstn      = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      tick();
   endtask

   task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1);
      req_valid = v;
      req_x1    = {a1, a0};
      req_x2    = {b1, b0};
   endtask

   // Alternation table: requester 0 holds op0 then op2, requester 1 holds op1 then op3.
   logic [31:0] alt_a0 [4] = '{32'h3FC00000, 32'h3FC00000, 32'h40400000, 32'h40400000};
   logic [31:0] alt_b0 [4] = '{32'h3FC00000, 32'h3FC00000, 32'h40400000, 32'h40400000};
   logic [31:0] alt_a1 [4] = '{32'h40000000, 32'h40000000, 32'hC0000000, 32'hC0000000};
   logic [31:0] alt_b1 [4] = '{32'h40000000, 32'h40000000, 32'h40800000, 32'h40800000};
   logic [1:0]  alt_gnt[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
   logic [31:0] alt_y  [4] = '{32'h40100000, 32'h40800000, 32'h41100000, 32'hC1000000};

   initial begin
      req_valid = '0;
      req_x1    = '0;
      req_x2    = '0;
      cnt_clr   = 1'b0;
      rstn      = 1'b0;
      #2;
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_resp_valid", 64'(resp_valid), 64'h0);
      chk("rst_resp_y", 64'(resp_y), 64'h0);
      chk("rst_resp_ovf", 64'(resp_ovf), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_ovf_cnt", 64'(ovf_cnt), 64'h0);
      tick();
      rstn = 1'b1;
      tick();

      // Single op 2*3 from requester 0.
      drive(2'b01, 32'h40000000, 32'h40400000, 32'h0, 32'h0);
      #1 chk("single_ready", 64'(req_ready), 64'h1);
      tick();
      req_valid = '0;
      chk("single_busy_s1", 64'(busy), 64'h1);
      chk("single_no_early_resp", 64'(resp_valid), 64'h0);
      tick();
      chk("single_resp_valid", 64'(resp_valid), 64'h1);
      chk("single_resp_y", 64'(resp_y), 64'h40C00000);
      chk("single_resp_ovf", 64'(resp_ovf), 64'h0);
      tick();
      chk("single_resp_once", 64'(resp_valid), 64'h0);
      chk("single_busy_done", 64'(busy), 64'h0);

      // Both requesters valid for four cycles: strict alternation.
      do_reset();
      for (int j = 0; j < 7; j++) begin
         if (j >= 2 && j < 6) begin
            chk($sformatf("alt_resp_valid%0d", j-2), 64'(resp_valid), 64'(alt_gnt[j-2]));
            chk($sformatf("alt_resp_y%0d", j-2), 64'(resp_y), 64'(alt_y[j-2]));
            chk($sformatf("alt_resp_ovf%0d", j-2), 64'(resp_ovf), 64'h0);
         end
         if (j < 4) begin
            drive(2'b11, alt_a0[j], alt_b0[j], alt_a1[j], alt_b1[j]);
            #1 chk($sformatf("alt_ready%0d", j), 64'(req_ready), 64'(alt_gnt[j]));
         end else begin
            req_valid = '0;
         end
         if (j == 6)
            chk("alt_drained", 64'(resp_valid), 64'h0);
         tick();
      end

      // Overflow from requester 1, then zero operand from requester 0.
      do_reset();
      drive(2'b10, 32'h0, 32'h0, 32'h7F000000, 32'h7F000000);
      #1 chk("ovf_ready", 64'(req_ready), 64'h2);
      tick();
      drive(2'b01, 32'h00000000, 32'h40000000, 32'h0, 32'h0);
      tick();
      req_valid = '0;
      chk("ovf_resp_valid", 64'(resp_valid), 64'h2);
      chk("ovf_resp_ovf", 64'(resp_ovf), 64'h1);
      chk("ovf_resp_y", 64'(resp_y), 64'h0);
      tick();
      chk("ovf_cnt1", 64'(ovf_cnt), 64'h10);
      chk("zero_resp_valid", 64'(resp_valid), 64'h1);
      chk("zero_resp_ovf", 64'(resp_ovf), 64'h1);
      chk("zero_resp_y", 64'(resp_y), 64'h0);
      tick();
      chk("zero_cnt0", 64'(ovf_cnt), 64'h11);

      // Twenty back-to-back ovf ops from requester 0 saturate its 4-bit counter.
      drive(2'b01, 32'h7F000000, 32'h7F000000, 32'h0, 32'h0);
      for (int k = 0; k < 20; k++) tick();
      req_valid = '0;
      for (int k = 0; k < 4; k++) tick();
      chk("sat_cnt", 64'(ovf_cnt), 64'h1F);
      drive(2'b01, 32'h00000000, 32'h3F800000, 32'h0, 32'h0);
      tick();
      req_valid = '0;
      for (int k = 0; k < 3; k++) tick();
      chk("sat_hold", 64'(ovf_cnt), 64'h1F);

      // Clear coincident with an ovf response: clear wins.
      drive(2'b01, 32'h7F000000, 32'h7F000000, 32'h0, 32'h0);
      tick();
      req_valid = '0;
      tick();
      chk("clr_resp_ovf", 64'(resp_ovf), 64'h1);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("clr_wins", 64'(ovf_cnt), 64'h0);
      tick();
      chk("clr_stays", 64'(ovf_cnt), 64'h0);

      // Requester 1 wins once to move rr_last, then reset mid-flight.
      drive(2'b10, 32'h0, 32'h0, 32'h40000000, 32'h40000000);
      tick();
      drive(2'b01, 32'h40000000, 32'h40400000, 32'h0, 32'h0);
      #1 chk("mid_ready", 64'(req_ready), 64'h1);
      tick();
      req_valid = '0;
      rstn      = 1'b0;
      #1;
      chk("mid_busy_rst", 64'(busy), 64'h0);
      chk("mid_valid_rst", 64'(resp_valid), 64'h0);
      tick();
      chk("mid_no_resp_a", 64'(resp_valid), 64'h0);
      tick();
      chk("mid_no_resp_b", 64'(resp_valid), 64'h0);
      rstn = 1'b1;
      tick();
      chk("mid_no_resp_c", 64'(resp_valid), 64'h0);
      drive(2'b11, 32'h40400000, 32'h40400000, 32'h40000000, 32'h40000000);
      #1 chk("mid_rr_reset", 64'(req_ready), 64'h1);
      tick();
      req_valid = '0;
      tick();
      chk("mid_reissue_y", 64'(resp_y), 64'h41100000);
      tick();

      // Idle: nothing moves and resp_y holds.
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("idle_ready%0d", k), 64'(req_ready), 64'h0);
         chk($sformatf("idle_valid%0d", k), 64'(resp_valid), 64'h0);
         chk($sformatf("idle_busy%0d", k), 64'(busy), 64'h0);
         chk($sformatf("idle_y%0d", k), 64'(resp_y), 64'h41100000);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
